// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//
// Contents:
//   NUM_REQ        number of requesters sharing the mux
//   SEL_W          width of the mux select / requester index
//   state_e        arbiter FSM state (IDLE: no grant, GRANT: a grant is active)
//   sel_to_onehot  turns a requester index into a one-hot grant vector
package mux_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker for four requesters.
//
// The requester after ptr has the highest priority. The scan order is
// ptr+1, ptr+2, ptr+3, ptr (mod 4), so ptr itself is chosen only when
// nobody else is requesting.
//
// Ports:
//   req   in   [3:0]  request vector, bit i = requester i
//   ptr   in   [1:0]  index of the most recently released requester
//   pick  out  [1:0]  index of the chosen requester (0 when any=0)
//   any   out         at least one request is set
module rr_pick4
    import mux_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   pick,
    output logic               any
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        any   = |req;
        for (int k = 1; k <= NUM_REQ; k++) begin
            // The 2-bit sum wraps, and k=4 lands on ptr itself.
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for a 4:1 data mux.
//
// Four producers share one downstream consumer. One requester is granted
// at a time, and the mux select follows the grant. A grant ends when its
// requester drops req, or after MAX_HOLD accepted beats. At that point the
// next requester in round-robin order is loaded at the same edge, so no
// idle cycle appears between grants.
//
// Handshake: a beat is transferred in every cycle where out_valid and
// out_ready are both high. out_valid is busy & req[sel]. A requester must
// keep its data stable while out_valid is high and out_ready is low.
//
// The FSM state is visible on busy (IDLE -> 0, GRANT -> 1).
//
// Ports:
//   clk        in              rising-edge clock
//   rst        in              synchronous reset, active-high
//   req        in   [3:0]      request per requester
//   in0..in3   in   [WIDTH-1:0] requester data
//   out_ready  in              consumer accepts a beat this cycle
//   gnt        out  [3:0]      registered one-hot grant, 0 when idle
//   sel        out  [1:0]      registered mux select (index of gnt)
//   out_data   out  [WIDTH-1:0] combinational mux of in[sel]
//   out_valid  out             busy & req[sel]
//   busy       out             registered, 1 while a grant is active
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e              state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    ptr_q;
    logic [7:0]          hold_cnt_q;

    logic [SEL_W-1:0]    pick_ptr;
    logic [SEL_W-1:0]    pick;
    logic                any;
    logic                beat;
    logic                release_grant;

    // While granted, the picker scans from sel. This is the same value
    // that ptr takes on release, so the next grant can be loaded at the
    // same edge. The current holder is re-picked only when it is alone.
    assign pick_ptr = (state_q == ST_GRANT) ? sel_q : ptr_q;

    rr_pick4 u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .pick (pick),
        .any  (any)
    );

    assign busy          = (state_q == ST_GRANT);
    assign out_valid     = busy & req[sel_q];
    assign beat          = out_valid & out_ready;
    assign release_grant = !req[sel_q] || (beat && (hold_cnt_q == HOLD_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            ptr_q      <= 2'd3;
            hold_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any) begin
                        gnt_q      <= sel_to_onehot(pick);
                        sel_q      <= pick;
                        hold_cnt_q <= '0;
                        state_q    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_grant) begin
                        ptr_q      <= sel_q;
                        hold_cnt_q <= '0;
                        if (any) begin
                            gnt_q <= sel_to_onehot(pick);
                            sel_q <= pick;
                        end else begin
                            gnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end
                    end else if (beat) begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt = gnt_q;
    assign sel = sel_q;

    always_comb begin
        case (sel_q)
            2'd0:    out_data = in0;
            2'd1:    out_data = in1;
            2'd2:    out_data = in2;
            default: out_data = in3;
        endcase
    end

endmodule
